// File: rtl/cache_wb_if.sv
// Command/response and write-back bundle between a core's load/store path and cache_wb.
// master = core/arbiter side, slave = cache side.
interface cache_wb_if #(
    parameter int TAG_WIDTH    = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 2
);
    localparam int LINE_WIDTH = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH;

    logic                  enable;
    logic [LINE_WIDTH-1:0] vector_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  hit_miss_out;
    logic                  busy;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [TAG_WIDTH-1:0]  wb_tag;
    logic [DATA_WIDTH-1:0] wb_data;

    modport master (
        output enable, vector_in, wb_ready,
        input  data_out, hit_miss_out, busy, wb_valid, wb_tag, wb_data
    );

    modport slave (
        input  enable, vector_in, wb_ready,
        output data_out, hit_miss_out, busy, wb_valid, wb_tag, wb_data
    );
endinterface

// File: rtl/cache_wb.sv
// Fully-associative write-back cache with dirty tracking, victim eviction and a
// valid/ready write-back port for evicted or flushed dirty lines.
// Opcodes: 0 = FLASH, 1 = READ, 2 = WRITE, 3 = INVALID (no-op).
// Build macro LRU_REPLACE_EN: age-counter LRU victim selection instead of round-robin.
module cache_wb #(
    parameter int TAG_WIDTH    = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int ENTRIES      = 64,
    parameter int OPCODE_WIDTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    cache_wb_if.slave bus
);
    localparam int IDX_W      = $clog2(ENTRIES);
    localparam int LINE_WIDTH = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH;
    localparam logic [OPCODE_WIDTH-1:0] OP_FLASH = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_READ  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = OPCODE_WIDTH'(2);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WB_WAIT, S_FLUSH_SCAN, S_FLUSH_WB} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      scan_q, scan_d;
    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [ENTRIES-1:0]    dirty_q, dirty_d;
    logic [TAG_WIDTH-1:0]  tag_q [ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_d [ENTRIES];
    logic [DATA_WIDTH-1:0] data_q [ENTRIES];
    logic [DATA_WIDTH-1:0] data_d [ENTRIES];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  hit_q, hit_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [TAG_WIDTH-1:0]  wb_tag_q, wb_tag_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic [OPCODE_WIDTH-1:0] cmd_op;
    logic [TAG_WIDTH-1:0]    cmd_tag;
    logic [DATA_WIDTH-1:0]   cmd_data;
    logic [ENTRIES-1:0]      match_vec;
    logic                    any_hit, any_free, accept;
    logic [IDX_W-1:0]        hit_idx, free_idx, victim_idx, alloc_idx;

    assign cmd_op   = bus.vector_in[LINE_WIDTH-1 -: OPCODE_WIDTH];
    assign cmd_tag  = bus.vector_in[DATA_WIDTH +: TAG_WIDTH];
    assign cmd_data = bus.vector_in[DATA_WIDTH-1:0];

    // Parallel tag compare; invalid entries never match.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign match_vec[gi] = valid_q[gi] && (tag_q[gi] == cmd_tag);
        end
    endgenerate

    assign any_hit   = |match_vec;
    assign any_free  = ~&valid_q;
    assign accept    = !bus.enable && (state_q == S_IDLE);
    assign alloc_idx = any_free ? free_idx : victim_idx;

    // Encode the matching entry and the lowest-index free slot.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) hit_idx = IDX_W'(i);
            if (!valid_q[i])  free_idx = IDX_W'(i);
        end
    end

`ifdef LRU_REPLACE_EN
    logic [IDX_W-1:0] age_q [ENTRIES];
    logic [IDX_W-1:0] age_d [ENTRIES];
    logic [IDX_W-1:0] best_age;
    logic             touch;
    logic [IDX_W-1:0] touch_idx;

    assign touch     = accept && ((cmd_op == OP_READ && any_hit) || cmd_op == OP_WRITE);
    assign touch_idx = any_hit ? hit_idx : alloc_idx;

    // Oldest entry is the victim; scanning downward with >= hands ties to the lowest index.
    always_comb begin
        best_age   = '0;
        victim_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (age_q[i] >= best_age) begin
                best_age   = age_q[i];
                victim_idx = IDX_W'(i);
            end
        end
    end

    // Touched entry becomes youngest; other valid entries age, saturating.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) age_d[i] = age_q[i];
        if (touch) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (IDX_W'(i) == touch_idx)           age_d[i] = '0;
                else if (valid_q[i] && age_q[i] != '1) age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    // Age counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) age_q[i] <= age_d[i];
        end
    end
`else
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             alloc_victim;

    assign alloc_victim = accept && (cmd_op == OP_WRITE) && !any_hit && !any_free;
    assign victim_idx   = rr_q;
    assign rr_d         = alloc_victim ? rr_q + 1'b1 : rr_q;

    // Round-robin victim pointer; advances only when a victim is actually replaced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end
`endif

    // Command decode, eviction, flush scan and write-back handshake.
    always_comb begin
        state_d    = state_q;
        scan_d     = scan_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        data_d     = data_q;
        data_out_d = data_out_q;
        hit_d      = hit_q;
        wb_valid_d = wb_valid_q;
        wb_tag_d   = wb_tag_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hit_d      = 1'b0;
                    data_out_d = '0;
                    case (cmd_op)
                        OP_READ: begin
                            if (any_hit) begin
                                hit_d      = 1'b1;
                                data_out_d = data_q[hit_idx];
                            end
                        end
                        OP_WRITE: begin
                            if (any_hit) begin
                                data_d[hit_idx]  = cmd_data;
                                dirty_d[hit_idx] = 1'b1;
                                hit_d            = 1'b1;
                            end else begin
                                // A dirty victim is parked in the wb register while the new line lands.
                                if (valid_q[alloc_idx] && dirty_q[alloc_idx]) begin
                                    wb_valid_d = 1'b1;
                                    wb_tag_d   = tag_q[alloc_idx];
                                    wb_data_d  = data_q[alloc_idx];
                                    state_d    = S_WB_WAIT;
                                end
                                valid_d[alloc_idx] = 1'b1;
                                dirty_d[alloc_idx] = 1'b1;
                                tag_d[alloc_idx]   = cmd_tag;
                                data_d[alloc_idx]  = cmd_data;
                            end
                        end
                        OP_FLASH: begin
                            scan_d  = '0;
                            state_d = S_FLUSH_SCAN;
                        end
                        default: ;
                    endcase
                end
            end
            S_WB_WAIT: begin
                if (wb_valid_q && bus.wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_FLUSH_SCAN: begin
                valid_d[scan_q] = 1'b0;
                dirty_d[scan_q] = 1'b0;
                if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    wb_valid_d = 1'b1;
                    wb_tag_d   = tag_q[scan_q];
                    wb_data_d  = data_q[scan_q];
                    state_d    = S_FLUSH_WB;
                end else if (scan_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            S_FLUSH_WB: begin
                if (wb_valid_q && bus.wb_ready) begin
                    wb_valid_d = 1'b0;
                    if (scan_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        scan_d  = scan_q + 1'b1;
                        state_d = S_FLUSH_SCAN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, storage and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            scan_q     <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            data_out_q <= '0;
            hit_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            scan_q     <= scan_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.hit_miss_out = hit_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_tag       = wb_tag_q;
    assign bus.wb_data      = wb_data_q;
endmodule
